// File: rtl/irq_bus_messenger.sv
// Interrupt-to-bus write engine: latches rising edges on the interrupt lines as pending,
// picks the lowest unmasked pending source and writes CHAR_BASE+index to BASE_ADDR.
module irq_bus_messenger #(
  parameter int unsigned              NUM_IRQ   = 4,
  parameter int unsigned              ADDR_W    = 64,
  parameter int unsigned              DATA_W    = 64,
  parameter logic [ADDR_W-1:0]        BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter logic [7:0]               CHAR_BASE = 8'h41,
  parameter int unsigned              MAX_WAIT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  output logic [ADDR_W-1:0]   bus_address,
  output logic [DATA_W-1:0]   bus_write_data,
  output logic                bus_write_enable,
  input  logic                bus_ready,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                busy,
  output logic                timeout_err,
  output logic [7:0]          overrun_count
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t              state_q;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q;
  logic [7:0]          wait_q;
  logic [7:0]          overrun_q, overrun_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                en_q, busy_q, timeout_q;

  logic [NUM_IRQ-1:0]  rise, req, clr, lost;
  logic [IDX_W-1:0]    sel;
  logic [7:0]          ch;
  logic                done;
  logic [4:0]          n_lost;
  logic [8:0]          ovr_sum;

  always_comb begin
    rise = irq & ~irq_q;
    req  = pending_q & ~irq_mask;

    sel = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req[i-1]) sel = IDX_W'(i - 1);
    end
    ch        = CHAR_BASE + 8'(sel);
    data_d    = '0;
    data_d[7:0] = ch;

    done = (state_q == WRITE) && (bus_ready || (wait_q == 8'(MAX_WAIT - 1)));
    clr  = '0;
    if (done) clr[idx_q] = 1'b1;

    // A rise on the edge that clears a source re-arms it and is not counted as lost
    pending_d = (pending_q & ~clr) | rise;
    lost      = rise & pending_q & ~clr;

    n_lost = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      n_lost = n_lost + 5'(lost[i]);
    end
    ovr_sum   = {1'b0, overrun_q} + 9'(n_lost);
    overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      overrun_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      irq_q     <= irq;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= WRITE;
            idx_q   <= sel;
            wait_q  <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= data_d;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        WRITE: begin
          if (done) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= ~bus_ready;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_address      = addr_q;
  assign bus_write_data   = data_q;
  assign bus_write_enable = en_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_q;
  assign pending          = pending_q;
  assign overrun_count    = overrun_q;

endmodule
